// File: rtl/freq_speed_sel.sv
// freq_speed_sel: synchronizes and debounces two speed buttons and keeps a
// saturating 8-bit rate word with press-step and hold-to-repeat behaviour.
module freq_speed_sel #(
    parameter int unsigned DEB_CYCLES    = 16,
    parameter int unsigned HOLD_CYCLES   = 64,
    parameter int unsigned REPEAT_CYCLES = 16,
    parameter logic [7:0]  RATE_INIT     = 8'h05,
    parameter logic [7:0]  RATE_MIN      = 8'h01,
    parameter logic [7:0]  RATE_MAX      = 8'hFF,
    parameter logic [7:0]  STEP          = 8'h01
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_dn,
    output logic [7:0] rate,
    output logic       rate_upd,
    output logic       at_min,
    output logic       at_max
);
    // debounce counter only has to reach DEB_CYCLES-1
    localparam int unsigned CW   = $clog2(DEB_CYCLES);
    localparam int unsigned TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX);

    typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT} state_t;

    // index 0 = up button, index 1 = down button
    logic [1:0]         sync1_q, sync2_q, deb_q;
    logic [1:0][CW-1:0] cnt_q;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          dir_q, dir_d;     // 1 = latched direction is up

    logic [7:0] rate_q, rate_d;
    logic       upd_q, min_q, max_q;

    logic       cmd_up, cmd_dn, step;
    logic [8:0] sum_up;
    logic [7:0] rate_inc, rate_dec;

    // two-flop synchronizer per button
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {btn_dn, btn_up};
            sync2_q <= sync1_q;
        end
    end

    // debounce: flip only after DEB_CYCLES consecutive mismatching samples
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            deb_q <= '0;
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CW'(DEB_CYCLES - 1)) begin
                    deb_q[i] <= sync2_q[i];
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign cmd_up = deb_q[0] & ~deb_q[1];
    assign cmd_dn = deb_q[1] & ~deb_q[0];

    // saturating step arithmetic, 9-bit so the up path cannot wrap
    always_comb begin
        sum_up   = {1'b0, rate_q} + {1'b0, STEP};
        rate_inc = (sum_up > {1'b0, RATE_MAX}) ? RATE_MAX : sum_up[7:0];
        rate_dec = ({1'b0, rate_q} < ({1'b0, RATE_MIN} + {1'b0, STEP})) ? RATE_MIN
                                                                          : rate_q - STEP;
    end

    // press/hold/repeat sequencer; any loss or change of command drops to idle
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        dir_d   = dir_q;
        step    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_up | cmd_dn) begin
                    step    = 1'b1;
                    dir_d   = cmd_up;
                    timer_d = TW'(HOLD_CYCLES - 1);
                    state_d = ST_DELAY;
                end
            end
            ST_DELAY, ST_REPEAT: begin
                if (!(cmd_up | cmd_dn) || (cmd_up != dir_q)) begin
                    state_d = ST_IDLE;
                end else if (timer_q == '0) begin
                    step    = 1'b1;
                    timer_d = TW'(REPEAT_CYCLES - 1);
                    state_d = ST_REPEAT;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // when stepping, cmd_up always matches the active direction
        rate_d = step ? (cmd_up ? rate_inc : rate_dec) : rate_q;
    end

    // FSM state, timer and direction latch
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            dir_q   <= dir_d;
        end
    end

    // registered rate word, change strobe and bound flags
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rate_q <= RATE_INIT;
            upd_q  <= 1'b0;
            min_q  <= (RATE_INIT == RATE_MIN);
            max_q  <= (RATE_INIT == RATE_MAX);
        end else begin
            rate_q <= rate_d;
            upd_q  <= (rate_d != rate_q);
            min_q  <= (rate_d == RATE_MIN);
            max_q  <= (rate_d == RATE_MAX);
        end
    end

    assign rate     = rate_q;
    assign rate_upd = upd_q;
    assign at_min   = min_q;
    assign at_max   = max_q;

endmodule
